zero_pattern_gen: RTL and testbench

ZERO_PATTERN_GEN -- requirements
Module: zero_pattern_gen

---
 rtl/zero_pattern_gen_pkg.sv | 28 ++
 rtl/zero_pattern_gen_if.sv | 14 +
 rtl/zero_pattern_gen_byte_zero_counter.sv | 12 +
 rtl/zero_pattern_gen.sv | 107 ++++++++++
 tb/tb_zero_pattern_gen.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zero_pattern_gen_pkg.sv
// Shared types and constants for the zero-pattern generator.
//   state_t   : controller states
//   MAX_ZEROS : largest legal zero count for an 8-bit value
//   BINOM     : C(8,k) for k = 0..8, i.e. number of patterns per target
package zero_pattern_gen_pkg;

  localparam int MAX_ZEROS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Entry k is C(8,k). The table is symmetric, so the listing order reads
  // the same from either end.
  localparam logic [8:0][6:0] BINOM = {
    7'd1, 7'd8, 7'd28, 7'd56, 7'd70, 7'd56, 7'd28, 7'd8, 7'd1
  };

  // Sequence length for a target; out-of-range targets never reach here
  // because they are rejected at start.
  function automatic logic [6:0] binom8(input logic [3:0] k);
    if (k > 4'(MAX_ZEROS)) return 7'd0;
    return BINOM[k];
  endfunction

endpackage

// File: rtl/zero_pattern_gen_if.sv
// Output stream of the zero-pattern generator.
//   out_data  : generated byte
//   out_valid : out_data holds a pattern
//   out_ready : downstream accept (transfer = valid & ready)
//   out_last  : final pattern of the sequence
interface zero_pattern_gen_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/zero_pattern_gen_byte_zero_counter.sv
// Combinational count of zero bits in a byte.
//   din   : byte under test
//   zeros : number of bits of din that are 0 (0..8)
module byte_zero_counter (
  input  logic [7:0] din,
  output logic [3:0] zeros
);
  always_comb begin
    zeros = '0;
    for (int i = 0; i < 8; i++) zeros = zeros + {3'b000, ~din[i]};
  end
endmodule

// File: rtl/zero_pattern_gen.sv
// Emits, in ascending order, every byte whose zero-bit count equals the
// requested count, over a valid/ready stream.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE
//   count_in   : wanted zero count (0..8); larger values raise err
//   busy       : high outside IDLE
//   done       : one-cycle pulse after the final transfer
//   err        : one-cycle pulse for an illegal count_in at start
//   stream     : pattern output (data/valid/last, ready back)
module zero_pattern_gen
  import zero_pattern_gen_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                count_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  zero_pattern_gen_if.master        stream
);

  state_t     state, state_nxt;
  logic [7:0] cand;
  logic [7:0] data_q;
  logic [3:0] target;
  logic [3:0] zeros;
  logic [6:0] emitted;
  logic       valid_q;
  logic       last_q;
  logic       hit;
  logic       xfer;
  logic       start_ok;

  byte_zero_counter u_zc (.din(cand), .zeros(zeros));

  assign hit      = (zeros == target);
  assign xfer     = valid_q && stream.out_ready;
  assign start_ok = start && (count_in <= 4'(MAX_ZEROS));

  assign busy             = (state != IDLE);
  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SCAN;
      SCAN:    if (hit) state_nxt = HOLD;
      HOLD:    if (xfer) state_nxt = last_q ? IDLE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= '0;
      data_q  <= '0;
      target  <= '0;
      emitted <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (start_ok) begin
            target  <= count_in;
            cand    <= '0;
            emitted <= '0;
          end else begin
            err <= 1'b1;
          end
        end
        SCAN: if (hit) begin
          data_q  <= cand;
          valid_q <= 1'b1;
          last_q  <= (emitted + 7'd1 == binom8(target));
        end else begin
          cand <= cand + 8'd1;
        end
        HOLD: if (xfer) begin
          valid_q <= 1'b0;
          if (last_q) begin
            // Candidate is left alone so it never steps past 0xFF.
            last_q <= 1'b0;
            done   <= 1'b1;
          end else begin
            emitted <= emitted + 7'd1;
            cand    <= cand + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_pattern_gen.sv
module tb_zero_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       busy, done, err;

  zero_pattern_gen_if sif ();

  zero_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .busy(busy), .done(done), .err(err), .stream(sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed transfers and events, sampled on the falling edge.
  logic [7:0] q_data[$];
  logic       q_last[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         valid_seen = 0;
  int         stall_err = 0;
  bit         stalled = 0;
  logic [7:0] held_data;
  logic       held_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled && (!sif.out_valid || sif.out_data !== held_data || sif.out_last !== held_last))
        stall_err++;
      if (sif.out_valid && sif.out_ready) begin
        q_data.push_back(sif.out_data);
        q_last.push_back(sif.out_last);
        stalled = 0;
      end else if (sif.out_valid) begin
        stalled = 1;
        held_data = sif.out_data;
        held_last = sif.out_last;
      end else begin
        stalled = 0;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (sif.out_valid) valid_seen++;
    end
  end

  function automatic int zeros_of(int v);
    logic [7:0] b;
    b = v[7:0];
    return 8 - $countones(b);
  endfunction

  task automatic clear_obs();
    q_data.delete();
    q_last.delete();
  endtask

  task automatic start_seq(input logic [3:0] k);
    start = 1'b1;
    count_in = k;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input bit rnd_ready, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd_ready) sif.out_ready = 1'($urandom_range(0, 1));
      if (done_cnt > base) begin ok = 1; break; end
    end
    sif.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sif.out_ready = 1'b0;
    #12;
    checks++;
    if ({busy, done, err, sif.out_valid, sif.out_last, sif.out_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, done, err, sif.out_valid, sif.out_last, sif.out_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_count8();
    int lat, d0;
    bit ok;
    clear_obs();
    d0 = done_cnt;
    sif.out_ready = 1'b1;
    start = 1'b1;
    count_in = 4'd8;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (sif.out_valid) break;
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL count8_latency: got %0d required 2", lat); end
    wait_done(d0, 50, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL count8_done: got timeout required done"); end
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL count8_num: got %0d required 1", q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 8'h00 || q_last[0] !== 1'b1) begin
        errors++; $display("FAIL count8_data: got %h/%b required 00/1", q_data[0], q_last[0]);
      end
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL count8_done_pulse: got %0d pulses busy=%b required 1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_count1();
    logic [7:0] exp [8];
    int d0;
    bit ok;
    exp = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    clear_obs();
    d0 = done_cnt;
    sif.out_ready = 1'b1;
    start_seq(4'd1);
    wait_done(d0, 600, 0, ok);
    checks++;
    if (!ok || q_data.size() != 8) begin
      errors++; $display("FAIL count1_num: got %0d done=%b required 8 done=1", q_data.size(), ok);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_data[i] !== exp[i] || q_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL count1_item%0d: got %h/%b required %h/%b", i, q_data[i], q_last[i], exp[i], (i == 7));
        end
      end
    end
  endtask

  task automatic test_count4_backpressure();
    logic [7:0] exp[$];
    int d0, bad;
    bit ok;
    for (int v = 0; v < 256; v++) if (zeros_of(v) == 4) exp.push_back(8'(v));
    clear_obs();
    d0 = done_cnt;
    stall_err = 0;
    sif.out_ready = 1'b0;
    start_seq(4'd4);
    wait_done(d0, 3000, 1, ok);
    checks++;
    if (!ok || q_data.size() != 70) begin
      errors++; $display("FAIL count4_num: got %0d done=%b required 70 done=1", q_data.size(), ok);
    end else begin
      bad = 0;
      for (int i = 0; i < 70; i++)
        if (q_data[i] !== exp[i] || q_last[i] !== (i == 69)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL count4_order: got %0d wrong items required 0", bad); end
      checks++;
      if (q_data[0] !== 8'h0F || q_data[69] !== 8'hF0) begin
        errors++; $display("FAIL count4_ends: got %h..%h required 0f..f0", q_data[0], q_data[69]);
      end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL count4_stall_stable: got %0d violations required 0", stall_err); end
  endtask

  task automatic test_err();
    int v0, e0;
    v0 = valid_seen;
    e0 = err_cnt;
    start = 1'b1;
    count_in = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got err=%b busy=%b required err=1 busy=0", err, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_width: got err=%b required 0", err); end
    repeat (5) @(posedge clk); #1;
    checks++;
    if (valid_seen != v0 || err_cnt != e0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_no_output: got valids=%0d errs=%0d busy=%b required 0/1/0", valid_seen - v0, err_cnt - e0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    clear_obs();
    d0 = done_cnt;
    sif.out_ready = 1'b1;
    start_seq(4'd4);
    for (int i = 0; i < 1000 && q_data.size() < 10; i++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, sif.out_valid, sif.out_last, sif.out_data} !== 12'h000) begin
      errors++; $display("FAIL midreset_outputs: got %b required all zero",
                         {busy, done, err, sif.out_valid, sif.out_last, sif.out_data});
    end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (done_cnt != d0 || q_data.size() != 10) begin
      errors++; $display("FAIL midreset_no_done: got done=%0d xfers=%0d required 0/10", done_cnt - d0, q_data.size());
    end
    clear_obs();
    start_seq(4'd0);
    wait_done(d0, 600, 0, ok);
    checks++;
    if (!ok || q_data.size() != 1) begin
      errors++; $display("FAIL count0_num: got %0d done=%b required 1 done=1", q_data.size(), ok);
    end else begin
      checks++;
      if (q_data[0] !== 8'hFF || q_last[0] !== 1'b1) begin
        errors++; $display("FAIL count0_data: got %h/%b required ff/1", q_data[0], q_last[0]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp[$];
    int d0, e0, bad, cyc;
    bit ok, busy_bad;
    for (int v = 0; v < 256; v++) if (zeros_of(v) == 2) exp.push_back(8'(v));
    clear_obs();
    d0 = done_cnt;
    e0 = err_cnt;
    sif.out_ready = 1'b1;
    start_seq(4'd2);
    ok = 0;
    busy_bad = 0;
    cyc = 0;
    while (cyc < 1000 && !ok) begin
      // Stray requests, one legal and one illegal, land mid-run.
      if (cyc == 5 || cyc == 40) begin start = 1'b1; count_in = (cyc == 5) ? 4'd8 : 4'd9; if (!busy) busy_bad = 1; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done_cnt > d0) ok = 1;
    end
    checks++;
    if (!ok || q_data.size() != 28 || busy_bad) begin
      errors++; $display("FAIL busy_start_num: got %0d done=%b required 28 done=1", q_data.size(), ok);
    end else begin
      bad = 0;
      for (int i = 0; i < 28; i++)
        if (q_data[i] !== exp[i] || q_last[i] !== (i == 27)) bad++;
      checks++;
      if (bad != 0 || q_data[27] !== 8'hFC) begin
        errors++; $display("FAIL busy_start_seq: got %0d wrong, last %h required 0 wrong, last fc", bad, q_data[27]);
      end
    end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL busy_start_err: got %0d err pulses required 0", err_cnt - e0); end
  endtask

  initial begin
    sif.out_ready = 1'b0;
    test_reset();
    test_count8();
    test_count1();
    test_count4_backpressure();
    test_err();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
